// File: rtl/systolic_pkg.sv
// systolic_pkg
// Shared types and default sizing for the systolic array GEMM loader.
//   loader_state_t : loader FSM states
//   ARRAY_DIM      : default rows/columns of the square array
//   DATA_W         : default element width (FP16)
//   ROW_IDX_W      : row index width for the default array size
//   CNT_W          : row counter width; one extra bit so the value ARRAY_DIM fits
package systolic_pkg;

    // A one-row array still needs a one-bit index.
    function automatic int row_idx_width(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

    localparam int ARRAY_DIM = 4;
    localparam int DATA_W    = 16;
    localparam int ROW_IDX_W = row_idx_width(ARRAY_DIM);
    localparam int CNT_W     = ROW_IDX_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_W,
        LOAD_W,
        WAIT_IN,
        LOAD_IN,
        DONE
    } loader_state_t;

endpackage

// File: rtl/loader_row_cnt.sv
// loader_row_cnt
// Clearable up-counter with enable and a terminal flag raised when the count
// equals array_dim. Clear has priority over enable.
// Ports:
//   CLK   in   clock
//   nRST  in   asynchronous active-low reset
//   clr   in   synchronous clear to zero
//   en    in   increment by one
//   cnt   out  current count (cnt_w bits)
//   term  out  cnt == array_dim
module loader_row_cnt
    import systolic_pkg::*;
#(
    parameter int array_dim = ARRAY_DIM,
    parameter int cnt_w     = CNT_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             clr,
    input  logic             en,
    output logic [cnt_w-1:0] cnt,
    output logic             term
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + cnt_w'(1);
        end
    end

    assign term = (cnt == cnt_w'(array_dim));

endmodule

// File: rtl/systolic_gemm_loader.sv
// systolic_gemm_loader
// Upstream feeder for the systolic array. Accepts one GEMM request at a time,
// loads array_dim weight rows (once the array is drained), then array_dim input
// rows and, when the request carries them, array_dim partial-sum rows in
// parallel (once the array FIFO has space). All array strobes are registered
// one cycle after their stream handshake.
//
// Optional build macro SYSTOLIC_LOADER_PERF_EN adds the saturating
// stall_cycles and gemm_count performance counters.
//
// Ports:
//   CLK, nRST                 clock, asynchronous active-low reset
//   req_valid/req_ready       GEMM request handshake, req_has_ps sampled with it
//   row_valid/ready/data      weight or input row stream
//   ps_valid/ready/data       partial-sum row stream
//   drained, fifo_has_space   array status flags, sampled in the wait states
//   weight_en/input_en/partial_en  one-cycle array strobes
//   row_in_en, row_ps_en      row indices for the strobed rows
//   array_in, array_in_partials    registered row data, held between strobes
//   done                      one-cycle pulse when the GEMM is fully issued
//   busy                      loader not idle
//   stall_cycles, gemm_count  (SYSTOLIC_LOADER_PERF_EN only)
module systolic_gemm_loader
    import systolic_pkg::*;
#(
    parameter int array_dim = ARRAY_DIM,
    parameter int data_w    = DATA_W
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_has_ps,
    input  logic                            row_valid,
    output logic                            row_ready,
    input  logic [data_w*array_dim-1:0]     row_data,
    input  logic                            ps_valid,
    output logic                            ps_ready,
    input  logic [data_w*array_dim-1:0]     ps_data,
    input  logic                            drained,
    input  logic                            fifo_has_space,
    output logic                            weight_en,
    output logic                            input_en,
    output logic                            partial_en,
    output logic [$clog2(array_dim)-1:0]    row_in_en,
    output logic [$clog2(array_dim)-1:0]    row_ps_en,
    output logic [data_w*array_dim-1:0]     array_in,
    output logic [data_w*array_dim-1:0]     array_in_partials,
    output logic                            done,
    output logic                            busy
`ifdef SYSTOLIC_LOADER_PERF_EN
    ,
    output logic [31:0]                     stall_cycles,
    output logic [15:0]                     gemm_count
`endif
);

    localparam int idx_w = $clog2(array_dim);
    localparam int cnt_w = idx_w + 1;

    loader_state_t    state;
    loader_state_t    state_next;
    logic             has_ps;
    logic             row_hs;
    logic             ps_hs;
    logic             row_clr;
    logic             ps_clr;
    logic [cnt_w-1:0] row_cnt;
    logic [cnt_w-1:0] ps_cnt;
    logic             row_term;
    logic             ps_term;
    logic             row_last;

    // One counter serves both weight and input rows: it is cleared on the
    // last weight row, so the input phase starts again from zero.
    loader_row_cnt #(
        .array_dim (array_dim),
        .cnt_w     (cnt_w)
    ) u_row_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .clr  (row_clr),
        .en   (row_hs),
        .cnt  (row_cnt),
        .term (row_term)
    );

    loader_row_cnt #(
        .array_dim (array_dim),
        .cnt_w     (cnt_w)
    ) u_ps_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .clr  (ps_clr),
        .en   (ps_hs),
        .cnt  (ps_cnt),
        .term (ps_term)
    );

    assign row_last = (row_cnt == cnt_w'(array_dim - 1));
    assign row_hs   = row_valid & row_ready;
    assign ps_hs    = ps_valid & ps_ready;
    assign row_clr  = ((state == LOAD_W) && row_hs && row_last) ||
                      (state == DONE) || (state == IDLE);
    assign ps_clr   = (state == DONE) || (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            has_ps <= 1'b0;
        end else begin
            state <= state_next;
            if (req_valid && req_ready) begin
                has_ps <= req_has_ps;
            end
        end
    end

    // The drained/fifo_has_space flags only matter in the wait states; once
    // loading starts they are ignored. In LOAD_IN the input and partial
    // streams advance independently and the phase ends when both are complete.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        row_ready  = 1'b0;
        ps_ready   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = WAIT_W;
                end
            end
            WAIT_W: begin
                if (drained) begin
                    state_next = LOAD_W;
                end
            end
            LOAD_W: begin
                row_ready = 1'b1;
                if (row_valid && row_last) begin
                    state_next = WAIT_IN;
                end
            end
            WAIT_IN: begin
                if (fifo_has_space) begin
                    state_next = LOAD_IN;
                end
            end
            LOAD_IN: begin
                row_ready = !row_term;
                ps_ready  = has_ps && !ps_term;
                if (row_term && (!has_ps || ps_term)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobes pulse for exactly the cycle after a handshake; indices and data
    // are captured with the handshake and held until the next one.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            weight_en         <= 1'b0;
            input_en          <= 1'b0;
            partial_en        <= 1'b0;
            row_in_en         <= '0;
            row_ps_en         <= '0;
            array_in          <= '0;
            array_in_partials <= '0;
        end else begin
            weight_en  <= row_hs && (state == LOAD_W);
            input_en   <= row_hs && (state == LOAD_IN);
            partial_en <= ps_hs;
            if (row_hs) begin
                row_in_en <= row_cnt[idx_w-1:0];
                array_in  <= row_data;
            end
            if (ps_hs) begin
                row_ps_en         <= ps_cnt[idx_w-1:0];
                array_in_partials <= ps_data;
            end
        end
    end

`ifdef SYSTOLIC_LOADER_PERF_EN
    logic stall_now;

    // A stall is any wait-state cycle, or a load cycle where a stream the
    // loader still needs has nothing to offer.
    assign stall_now = (state == WAIT_W) || (state == WAIT_IN) ||
                       ((state == LOAD_W) && !row_valid) ||
                       ((state == LOAD_IN) &&
                        ((!row_term && !row_valid) ||
                         (has_ps && !ps_term && !ps_valid)));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles <= '0;
            gemm_count   <= '0;
        end else begin
            if (stall_now && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (done && (gemm_count != '1)) begin
                gemm_count <= gemm_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_systolic_gemm_loader.sv
// tb_systolic_gemm_loader
// Directed bench for systolic_gemm_loader. A transaction-level model holds the
// rows each GEMM must deliver (row index + data, in order per stream) and a
// compare process checks every strobe, done, busy and req_ready against it on
// every cycle. Per-test literal latencies pin the model to hand-worked timing.
module tb_systolic_gemm_loader;

    localparam int DIM = 4;
    localparam int DW  = 16;
    localparam int BW  = DIM * DW;

    typedef struct packed {
        logic [1:0]    row;
        logic [BW-1:0] data;
    } exp_t;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          req_valid;
    logic          req_ready;
    logic          req_has_ps;
    logic          row_valid;
    logic          row_ready;
    logic [BW-1:0] row_data;
    logic          ps_valid;
    logic          ps_ready;
    logic [BW-1:0] ps_data;
    logic          drained;
    logic          fifo_has_space;
    logic          weight_en;
    logic          input_en;
    logic          partial_en;
    logic [1:0]    row_in_en;
    logic [1:0]    row_ps_en;
    logic [BW-1:0] array_in;
    logic [BW-1:0] array_in_partials;
    logic          done;
    logic          busy;
`ifdef SYSTOLIC_LOADER_PERF_EN
    logic [31:0]   stall_cycles;
    logic [15:0]   gemm_count;
`endif

    systolic_gemm_loader #(
        .array_dim (DIM),
        .data_w    (DW)
    ) dut (
        .CLK               (CLK),
        .nRST              (nRST),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_has_ps        (req_has_ps),
        .row_valid         (row_valid),
        .row_ready         (row_ready),
        .row_data          (row_data),
        .ps_valid          (ps_valid),
        .ps_ready          (ps_ready),
        .ps_data           (ps_data),
        .drained           (drained),
        .fifo_has_space    (fifo_has_space),
        .weight_en         (weight_en),
        .input_en          (input_en),
        .partial_en        (partial_en),
        .row_in_en         (row_in_en),
        .row_ps_en         (row_ps_en),
        .array_in          (array_in),
        .array_in_partials (array_in_partials),
        .done              (done),
        .busy              (busy)
`ifdef SYSTOLIC_LOADER_PERF_EN
        ,
        .stall_cycles      (stall_cycles),
        .gemm_count        (gemm_count)
`endif
    );

    always #5 CLK = ~CLK;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    // Model state
    exp_t expW[$];
    exp_t expI[$];
    exp_t expP[$];
    bit   gemmActive = 0;
    bit   curHasPs   = 0;
    int   rowHs      = 0;
    int   psHs       = 0;
    int   doneDue    = -1;
    int   firstWCyc  = -1;
    int   firstICyc  = -1;
    int   firstPCyc  = -1;
    int   doneCyc    = -1;
    int   doneCount  = 0;
    bit   pendW      = 0;
    bit   pendI      = 0;
    bit   pendP      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic noteFail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: event not allowed here (cycle %0d)", name, cyc);
    endtask

    function automatic logic [BW-1:0] mkRow(input int tag, input int i);
        return {16'(tag), 16'(i), 16'(tag * 3 + i), 16'hC000 | 16'(i)};
    endfunction

    function automatic exp_t mkExp(input int tag, input int i);
        exp_t e;
        e.row  = 2'(i);
        e.data = mkRow(tag, i);
        return e;
    endfunction

    task automatic clearModel();
        expW.delete();
        expI.delete();
        expP.delete();
        gemmActive = 0;
        doneDue    = -1;
        rowHs      = 0;
        psHs       = 0;
    endtask

    // Compare process: every cycle, strobes must match the handshakes of the
    // previous cycle, each strobe must carry the next expected row, and done
    // must land exactly one cycle after the final strobe of the GEMM.
    always @(negedge CLK) begin
        exp_t e;
        bit   popped;
        if (!nRST) begin
            pendW = 0;
            pendI = 0;
            pendP = 0;
        end else begin
            popped = 0;
            checkOutput("weight_en", BW'(weight_en), BW'(pendW));
            checkOutput("input_en", BW'(input_en), BW'(pendI));
            checkOutput("partial_en", BW'(partial_en), BW'(pendP));
            if (weight_en) begin
                if (expW.size() == 0) noteFail("extra_weight_strobe");
                else begin
                    e = expW.pop_front();
                    checkOutput("weight_row", BW'(row_in_en), BW'(e.row));
                    checkOutput("weight_data", array_in, e.data);
                    if (e.row == 2'd0) firstWCyc = cyc;
                    popped = 1;
                end
            end
            if (input_en) begin
                if (expI.size() == 0) noteFail("extra_input_strobe");
                else begin
                    e = expI.pop_front();
                    checkOutput("input_row", BW'(row_in_en), BW'(e.row));
                    checkOutput("input_data", array_in, e.data);
                    if (e.row == 2'd0) firstICyc = cyc;
                    popped = 1;
                end
            end
            if (partial_en) begin
                if (expP.size() == 0) noteFail("extra_partial_strobe");
                else begin
                    e = expP.pop_front();
                    checkOutput("partial_row", BW'(row_ps_en), BW'(e.row));
                    checkOutput("partial_data", array_in_partials, e.data);
                    if (e.row == 2'd0) firstPCyc = cyc;
                    popped = 1;
                end
            end
            checkOutput("done", BW'(done), BW'(gemmActive && (cyc == doneDue)));
            checkOutput("busy", BW'(busy), BW'(gemmActive));
            checkOutput("req_ready", BW'(req_ready), BW'(!gemmActive));
            if (!curHasPs) checkOutput("ps_ready_gated", BW'(ps_ready), BW'(0));
            if (done) begin
                doneCyc    = cyc;
                gemmActive = 0;
                doneCount++;
            end
            if (popped && gemmActive && expW.size() == 0 && expI.size() == 0 && expP.size() == 0)
                doneDue = cyc + 1;
            pendW = 0;
            pendI = 0;
            if (row_valid && row_ready) begin
                if (rowHs < DIM) pendW = 1;
                else if (rowHs < 2 * DIM) pendI = 1;
                else noteFail("extra_row_handshake");
                rowHs++;
            end
            pendP = ps_valid && ps_ready;
            if (pendP) begin
                if (!curHasPs || psHs >= DIM) noteFail("extra_ps_handshake");
                psHs++;
            end
        end
    end

    task automatic checkResetState();
        checkOutput("rst_weight_en", BW'(weight_en), BW'(0));
        checkOutput("rst_input_en", BW'(input_en), BW'(0));
        checkOutput("rst_partial_en", BW'(partial_en), BW'(0));
        checkOutput("rst_done", BW'(done), BW'(0));
        checkOutput("rst_busy", BW'(busy), BW'(0));
        checkOutput("rst_req_ready", BW'(req_ready), BW'(1));
        checkOutput("rst_row_ready", BW'(row_ready), BW'(0));
        checkOutput("rst_ps_ready", BW'(ps_ready), BW'(0));
        checkOutput("rst_row_in_en", BW'(row_in_en), BW'(0));
        checkOutput("rst_row_ps_en", BW'(row_ps_en), BW'(0));
        checkOutput("rst_array_in", array_in, BW'(0));
        checkOutput("rst_array_in_partials", array_in_partials, BW'(0));
    endtask

    // Entered and left just after a rising edge.
    task automatic issueReq(input bit hasPs, output int acceptCyc);
        int k;
        k = 0;
        req_valid  = 1;
        req_has_ps = hasPs;
        @(negedge CLK);
        while (!req_ready && k < 50) begin
            k++;
            @(negedge CLK);
        end
        if (!req_ready) noteFail("req_timeout");
        @(posedge CLK);
        #1;
        req_valid  = 0;
        req_has_ps = 0;
        acceptCyc  = cyc;
        gemmActive = 1;
        curHasPs   = hasPs;
        rowHs      = 0;
        psHs       = 0;
        doneDue    = -1;
        firstWCyc  = -1;
        firstICyc  = -1;
        firstPCyc  = -1;
        doneCyc    = -1;
    endtask

    task automatic driveRow(input logic [BW-1:0] d);
        int k;
        k = 0;
        row_valid = 1;
        row_data  = d;
        @(negedge CLK);
        while (!row_ready && k < 60) begin
            k++;
            @(negedge CLK);
        end
        if (!row_ready) noteFail("row_timeout");
        @(posedge CLK);
        #1;
        row_valid = 0;
    endtask

    task automatic drivePs(input logic [BW-1:0] d);
        int k;
        k = 0;
        ps_valid = 1;
        ps_data  = d;
        @(negedge CLK);
        while (!ps_ready && k < 60) begin
            k++;
            @(negedge CLK);
        end
        if (!ps_ready) noteFail("ps_timeout");
        @(posedge CLK);
        #1;
        ps_valid = 0;
    endtask

    // Runs one complete GEMM and reports first-weight, first-input,
    // first-partial and done cycles relative to the request accept edge.
    task automatic applyStimulus(input bit hasPs, input int drainDelay, input int psDelay,
                                 input int inGap, input bit fifoGlitch, input int tag,
                                 output int rW, output int rI, output int rP, output int rD);
        int a;
        int k;
        for (int i = 0; i < DIM; i++) expW.push_back(mkExp(tag, i));
        for (int i = 0; i < DIM; i++) expI.push_back(mkExp(tag + 1, i));
        if (hasPs) for (int i = 0; i < DIM; i++) expP.push_back(mkExp(tag + 2, i));
        drained        = (drainDelay == 0);
        fifo_has_space = 1;
        issueReq(hasPs, a);
        fork
            begin
                for (int i = 0; i < DIM; i++) driveRow(mkRow(tag, i));
                for (int i = 0; i < DIM; i++) begin
                    driveRow(mkRow(tag + 1, i));
                    repeat (inGap) begin
                        @(posedge CLK);
                        #1;
                    end
                end
            end
            begin
                if (drainDelay > 0) begin
                    repeat (drainDelay) begin
                        @(negedge CLK);
                        checkOutput("wait_w_row_ready", BW'(row_ready), BW'(0));
                        checkOutput("wait_w_weight_en", BW'(weight_en), BW'(0));
                        @(posedge CLK);
                        #1;
                    end
                    drained = 1;
                end
            end
            begin
                if (hasPs) begin
                    repeat (5 + psDelay) begin
                        @(posedge CLK);
                        #1;
                    end
                    for (int i = 0; i < DIM; i++) drivePs(mkRow(tag + 2, i));
                end
            end
            begin
                if (fifoGlitch) begin
                    repeat (8) begin
                        @(posedge CLK);
                        #1;
                    end
                    fifo_has_space = 0;
                    repeat (3) begin
                        @(posedge CLK);
                        #1;
                    end
                    fifo_has_space = 1;
                end
            end
        join
        k = 0;
        while (gemmActive && k < 40) begin
            @(posedge CLK);
            #1;
            k++;
        end
        if (gemmActive) begin
            noteFail("done_timeout");
            clearModel();
        end
        rW = firstWCyc - a;
        rI = firstICyc - a;
        rP = firstPCyc - a;
        rD = doneCyc - a;
    endtask

    initial begin
        int a;
        int rW;
        int rI;
        int rP;
        int rD;
        nRST           = 0;
        req_valid      = 0;
        req_has_ps     = 0;
        row_valid      = 0;
        row_data       = '0;
        ps_valid       = 0;
        ps_data        = '0;
        drained        = 1;
        fifo_has_space = 1;
        #3;
        checkResetState();
        @(negedge CLK);
        #2;
        nRST = 1;
        @(posedge CLK);
        #1;

        // Test 1: reset after two weight rows abandons the GEMM.
        $display("[TB] test 1: reset mid LOAD_W");
        expW.push_back(mkExp(16'h10, 0));
        expW.push_back(mkExp(16'h10, 1));
        issueReq(0, a);
        driveRow(mkRow(16'h10, 0));
        driveRow(mkRow(16'h10, 1));
        @(negedge CLK);
        #2;
        nRST = 0;
        clearModel();
        doneCount = 0;
        #1;
        checkResetState();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #2;
        nRST = 1;
        @(posedge CLK);
        #1;
        row_valid = 1;
        row_data  = mkRow(16'h11, 0);
        repeat (3) begin
            @(negedge CLK);
            checkOutput("idle_row_ready", BW'(row_ready), BW'(0));
            @(posedge CLK);
            #1;
        end
        row_valid = 0;

        // Test 2: no partials, back-to-back rows; stray ps_valid must be ignored.
        $display("[TB] test 2: basic GEMM without partial sums");
        ps_valid = 1;
        ps_data  = mkRow(16'hEE, 7);
        applyStimulus(0, 0, 0, 0, 0, 16'h20, rW, rI, rP, rD);
        ps_valid = 0;
        checkOutput("t2_first_weight", BW'(rW), BW'(2));
        checkOutput("t2_first_input", BW'(rI), BW'(7));
        checkOutput("t2_done", BW'(rD), BW'(11));

        // Test 3: array not drained for 10 cycles.
        $display("[TB] test 3: drained held low");
        applyStimulus(0, 10, 0, 0, 0, 16'h30, rW, rI, rP, rD);
        checkOutput("t3_first_weight", BW'(rW), BW'(12));
        checkOutput("t3_first_input", BW'(rI), BW'(17));
        checkOutput("t3_done", BW'(rD), BW'(21));

        // Test 4: partial sums trailing the input rows by 3 cycles.
        $display("[TB] test 4: partial sums delayed");
        applyStimulus(1, 0, 3, 0, 0, 16'h40, rW, rI, rP, rD);
        checkOutput("t4_first_input", BW'(rI), BW'(7));
        checkOutput("t4_first_partial", BW'(rP), BW'(9));
        checkOutput("t4_done", BW'(rD), BW'(13));

        // Test 5: input rows every other cycle, fifo_has_space glitch in LOAD_IN.
        $display("[TB] test 5: gapped input rows");
        applyStimulus(0, 0, 0, 1, 1, 16'h50, rW, rI, rP, rD);
        checkOutput("t5_first_input", BW'(rI), BW'(7));
        checkOutput("t5_done", BW'(rD), BW'(14));

        checkOutput("done_count", BW'(doneCount), BW'(4));
`ifdef SYSTOLIC_LOADER_PERF_EN
        checkOutput("gemm_count", BW'(gemm_count), BW'(4));
`endif
        repeat (2) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_gemm_loader.md
Name: systolic_gemm_loader

Overview:
Upstream feeder for the systolic array. Accepts one GEMM request at a time and pulls weight, input and optional partial-sum rows from scratchpad-side valid/ready streams. Drives the array's weight/input/partial enables, row indices and data buses. Each GEMM runs as a weight phase followed by an input phase, gated by the array's drained and fifo_has_space flags.

Parameters:
array_dim, 4, rows/columns of the square array; row index width is $clog2(array_dim)
data_w, 16, element width (FP16)

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
req_valid  in  1  GEMM request offered
req_ready  out  1  loader idle and able to accept
req_has_ps  in  1  request carries partial sums (sampled with the request)
row_valid  in  1  weight/input row available
row_ready  out  1  loader consumes the row this cycle
row_data  in  data_w*array_dim  weight or input row
ps_valid  in  1  partial-sum row available
ps_ready  out  1  loader consumes the partial row this cycle
ps_data  in  data_w*array_dim  partial-sum row
drained  in  1  array fully drained
fifo_has_space  in  1  array can accept another GEMM
weight_en, input_en, partial_en  out  1 each  registered array strobes
row_in_en  out  $clog2(array_dim)  weight/input row index
row_ps_en  out  $clog2(array_dim)  partial row index
array_in  out  data_w*array_dim  registered row data
array_in_partials  out  data_w*array_dim  registered partial data
done  out  1  one-cycle pulse when the GEMM is fully issued
busy  out  1  state != IDLE

Behaviour:
- Reset (async, nRST low): state IDLE; all outputs 0 except req_ready = 1; both counters 0. Reset mid-GEMM abandons the GEMM with no drain.
- States: IDLE, WAIT_W, LOAD_W, WAIT_IN, LOAD_IN, DONE.
- IDLE: req_ready = 1. Request accept (req_valid & req_ready) latches has_ps and goes to WAIT_W.
- WAIT_W: stay until drained = 1, then go to LOAD_W. Weights are never overwritten while the array computes.
- LOAD_W: row_ready = 1. Each row handshake registers weight_en = 1, row_in_en = w_cnt and array_in = row_data on the next cycle (1-cycle latency). w_cnt increments. After row array_dim-1, clear w_cnt and go to WAIT_IN.
- WAIT_IN: stay until fifo_has_space = 1, then go to LOAD_IN.
- LOAD_IN: row_ready = 1 while in_cnt < array_dim. Each handshake registers input_en with row_in_en = in_cnt.
- Partial path, only when has_ps: ps_ready = 1 while ps_cnt < array_dim. It runs independently of the input path and in the same cycles. Each handshake registers partial_en, row_ps_en = ps_cnt and array_in_partials.
- When has_ps = 0: ps_ready stays 0 and partial_en is never asserted.
- Leave LOAD_IN when in_cnt == array_dim and (has_ps == 0 or ps_cnt == array_dim). Go to DONE.
- DONE: one cycle; done = 1; counters clear; go to IDLE. The next request can be accepted the following cycle.
- Strobes: all strobes are 1-cycle pulses; no strobe is asserted without a handshake in the prior cycle.
- Held outputs: array_in and array_in_partials hold their last value when not strobed.
- Stalls: deasserted row_valid or ps_valid holds counters; no bubble is inserted beyond the stall.
- Flags are level-sampled only in the WAIT states. Their deassertion during LOAD states is ignored.
- Counters: width $clog2(array_dim)+1 so the terminal value array_dim fits. Outputs take the low $clog2(array_dim) bits.
- Unexpected streams: a row_valid in IDLE, WAIT_W or WAIT_IN is not consumed (row_ready = 0). Likewise, a ps_valid arriving early is not consumed.

Optional Feature:
SYSTOLIC_LOADER_PERF_EN: adds outputs stall_cycles [31:0] and gemm_count [15:0].
- stall_cycles counts cycles in WAIT_W/WAIT_IN, plus LOAD states with a needed stream not valid.
- gemm_count increments on done.
- Both reset to 0 and saturate.
- Without the macro: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- systolic_pkg: loader_state_t enum; ARRAY_DIM / DATA_W defaults; ROW_IDX_W and CNT_W localparams.
- Sub-module loader_row_cnt: a clearable counter with enable and terminal flag (cnt == array_dim). Instantiated twice, for the weight/input row counter and the partial-sum counter.

Test Plan:
1. Reset mid-LOAD_W (after 2 rows), then release → outputs zero, req_ready = 1, state IDLE, no strobes.
2. Request with has_ps = 0, drained = 1, fifo_has_space = 1, rows W0..W3 then I0..I3 streamed back-to-back → expected response:
   - weight_en on 4 consecutive cycles with row_in_en 0,1,2,3, each 1 cycle after its handshake;
   - then input_en on 4 cycles with rows 0..3;
   - partial_en never asserted;
   - done 1 cycle after the last strobe.
3. drained = 0 for 10 cycles after the request → row_ready = 0 and no weight_en; weight loading starts the cycle after drained rises.
4. Request with has_ps = 1 and ps_valid delayed 3 cycles behind row_valid → input_en rows 0..3 and partial_en rows 0..3 each appear exactly once; done follows the last partial strobe.
5. row_valid toggling every other cycle in LOAD_IN → input_en follows each handshake with correct row_in_en, no duplicates; fifo_has_space dropped mid-LOAD_IN has no effect.
6. With SYSTOLIC_LOADER_PERF_EN defined, two GEMMs with 5 forced wait cycles each → gemm_count = 2, stall_cycles = 10.
